// File: rtl/countdown_bcd_3_digits.sv
// 3-digit BCD countdown timer with prescaled tick and active-low 7-seg outputs.
// Optional TIMER_BLINK_EN: digits blink in DONE.
module countdown_bcd_3_digits #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        CLOCK_50,
  input  logic        aclr,
  input  logic        load,
  input  logic        run,
  input  logic [11:0] load_val,
  output logic [11:0] bcd,
  output logic [6:0]  H0,
  output logic [6:0]  H1,
  output logic [6:0]  H2,
  output logic        zero,
  output logic        done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [11:0]   cnt, cnt_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          done_nx;
  logic          tick;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [11:0] dec_bcd(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (d0 != 4'd0) begin
      d0 = d0 - 4'd1;
    end else begin
      d0 = 4'd9;
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
      end else begin
        d1 = 4'd9;
        d2 = d2 - 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  // {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tick = (state == RUN) && (presc == TOP);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    presc_nx = presc;
    done_nx  = 1'b0;
    if (load) begin
      cnt_nx   = {clamp9(load_val[11:8]),
                  clamp9(load_val[7:4]),
                  clamp9(load_val[3:0])};
      presc_nx = '0;
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (run && (cnt != 12'h000)) state_nx = RUN;
        end
        RUN: begin
          // pausing keeps the prescaler phase
          if (!run) begin
            state_nx = IDLE;
          end else if (tick) begin
            presc_nx = '0;
            cnt_nx   = dec_bcd(cnt);
            if (cnt == 12'h001) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end
          end else begin
            presc_nx = presc + 1'b1;
          end
        end
        DONE: begin
          state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge aclr) begin
    if (aclr) begin
      state <= IDLE;
      cnt   <= 12'h000;
      presc <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      presc <= presc_nx;
      done  <= done_nx;
    end
  end

  assign bcd  = cnt;
  assign zero = (cnt == 12'h000);

`ifdef TIMER_BLINK_EN
  localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);
  logic [PW-1:0] blink_cnt;
  logic          blank;

  always_ff @(posedge CLOCK_50 or posedge aclr) begin
    if (aclr) begin
      blink_cnt <= '0;
    end else if (state == DONE && state_nx == DONE) begin
      blink_cnt <= (blink_cnt == TOP) ? '0 : blink_cnt + 1'b1;
    end else begin
      blink_cnt <= '0;
    end
  end

  assign blank = (state == DONE) && (blink_cnt < HALF);
  assign H0 = blank ? 7'h7F : seg7(cnt[3:0]);
  assign H1 = blank ? 7'h7F : seg7(cnt[7:4]);
  assign H2 = blank ? 7'h7F : seg7(cnt[11:8]);
`else
  assign H0 = seg7(cnt[3:0]);
  assign H1 = seg7(cnt[7:4]);
  assign H2 = seg7(cnt[11:8]);
`endif

endmodule
